// File: rtl/uart_param.sv
`default_nettype none
// ============================================================================
// uart_param : parametrised full-duplex UART (divisor, width, stops, parity).
// Optional parity generation/checking is compiled in with UART_PARITY_EN.
// Revision   : 1.0
// ============================================================================
module uart_param #(
  parameter int CLK_DIV   = 434,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0
) (
  input  logic                 clk100,
  input  logic                 reset,
  input  logic                 rx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 send,
  output logic                 tx,
  output logic                 busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
  localparam logic PAR_ON  = (PARITY != 0);
  localparam logic PAR_ODD = (PARITY == 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef UART_PARITY_EN
    S_PAR   = 3'd3,
`endif
    S_STOP  = 3'd4
  } state_t;

  // An out-of-range PARITY setting is a configuration error; no logic results.
  if (PARITY < 0 || PARITY > 2) begin : g_parity_range
  end

  // ---------------------------------------------------------------- RX path
  logic                 rx_meta, rxs, rxs_prev;
  state_t               rx_state, rx_next;
  logic [15:0]          rx_cnt;
  logic [2:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_sample;
`ifdef UART_PARITY_EN
  logic                 rx_par_bit;
`endif

  always_ff @(posedge clk100) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  always_comb begin
    rx_next   = rx_state;
    rx_sample = 1'b0;
    case (rx_state)
      S_IDLE:  if (rxs_prev && !rxs) rx_next = S_START;
      S_START: if (rx_cnt == HALF_LAST) begin
        rx_sample = 1'b1;
        rx_next   = rxs ? S_IDLE : S_DATA;
      end
      S_DATA:  if (rx_cnt == DIV_LAST) begin
        rx_sample = 1'b1;
        if (rx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
          rx_next = PAR_ON ? S_PAR : S_STOP;
`else
          rx_next = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PAR:   if (rx_cnt == DIV_LAST) begin
        rx_sample = 1'b1;
        rx_next   = S_STOP;
      end
`endif
      S_STOP:  if (rx_cnt == DIV_LAST) begin
        rx_sample = 1'b1;
        rx_next   = S_IDLE;
      end
      default: rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      rx_state   <= S_IDLE;
      rx_cnt     <= 16'd0;
      rx_bit     <= 3'd0;
      rx_shift   <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bit <= 1'b0;
`endif
    end else begin
      rx_state <= rx_next;
      rx_valid <= 1'b0;
      rx_cnt   <= (rx_state == S_IDLE || rx_sample) ? 16'd0 : rx_cnt + 16'd1;
      if (rx_sample) begin
        case (rx_state)
          S_START: rx_bit <= 3'd0;
          S_DATA: begin
            rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
            rx_bit   <= rx_bit + 3'd1;
          end
`ifdef UART_PARITY_EN
          S_PAR:   rx_par_bit <= rxs;
`endif
          // Leave for IDLE at mid-stop so a start edge inside the stop bit is seen.
          S_STOP: begin
            rx_data   <= rx_shift;
            rx_valid  <= 1'b1;
            frame_err <= ~rxs;
`ifdef UART_PARITY_EN
            parity_err <= PAR_ON && ((^rx_shift ^ PAR_ODD) != rx_par_bit);
`else
            parity_err <= 1'b0;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- TX path
  state_t               tx_state, tx_next;
  logic [15:0]          tx_cnt;
  logic [2:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_stop;
  logic                 tx_tick;
  logic                 tx_stop_last;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_tick      = (tx_cnt == DIV_LAST);
  assign tx_stop_last = (tx_stop == 1'(STOP_BITS - 1));

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:  if (send && !busy) tx_next = S_START;
      S_START: if (tx_tick) tx_next = S_DATA;
      S_DATA:  if (tx_tick && tx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
        tx_next = PAR_ON ? S_PAR : S_STOP;
`else
        tx_next = S_STOP;
`endif
      end
`ifdef UART_PARITY_EN
      S_PAR:   if (tx_tick) tx_next = S_STOP;
`endif
      S_STOP:  if (tx_tick && tx_stop_last) tx_next = S_IDLE;
      default: tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= '0;
      tx_stop  <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= (tx_state == S_IDLE || tx_tick) ? 16'd0 : tx_cnt + 16'd1;
      case (tx_state)
        S_IDLE: if (send && !busy) begin
          tx_shift <= tx_data;
          tx       <= 1'b0;
          busy     <= 1'b1;
          tx_bit   <= 3'd0;
          tx_stop  <= 1'b0;
`ifdef UART_PARITY_EN
          tx_par   <= ^tx_data ^ PAR_ODD;
`endif
        end
        S_START: if (tx_tick) tx <= tx_shift[0];
        S_DATA: if (tx_tick) begin
          tx_bit   <= tx_bit + 3'd1;
          tx_shift <= tx_shift >> 1;
          if (tx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
            tx <= PAR_ON ? tx_par : 1'b1;
`else
            tx <= 1'b1;
`endif
          end else begin
            tx <= tx_shift[1];
          end
        end
`ifdef UART_PARITY_EN
        S_PAR: if (tx_tick) tx <= 1'b1;
`endif
        S_STOP: if (tx_tick) begin
          if (tx_stop_last) busy <= 1'b0;
          else              tx_stop <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_param.md
# uart_param

Parametrised full-duplex UART replacing the fixed 8N1 serial block. Baud divisor, data width, stop-bit count and parity mode are set per instance. It sits between the board RX/TX pins and the byte-level control logic on the 100 MHz domain. It adds glitch-rejecting start detection, framing and parity error flags, and a strict send/busy handshake.

## Interface
- CLK_DIV, 434: clocks per bit (100 MHz / 230400); legal 4..65535.
- DATA_BITS, 8: data bits per frame; legal 5..8.
- STOP_BITS, 1: TX stop bits, 1 or 2. RX checks only the first stop bit.
- PARITY, 0: 0 none, 1 odd, 2 even. Only effective with UART_PARITY_EN.

- clk100  in  1  system clock, 100 MHz, the only clock.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- tx_data  in  DATA_BITS  byte to send; sampled on an accepted send.
- send  in  1  request strobe; accepted only when busy=0.
- tx  out  1  serial output, idle high.
- busy  out  1  TX frame in progress.
- rx_data  out  DATA_BITS  last received word, LSB first on the line.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- frame_err  out  1  qualifies rx_valid: stop bit sampled low.
- parity_err  out  1  qualifies rx_valid: parity mismatch.

## Operation
- Reset values: tx=1, busy=0, rx_data=0, rx_valid=0, frame_err=0, parity_err=0. Both FSMs go to IDLE and all counters clear.
- rx passes through a 2-flop synchroniser (rxs) before any use.
- One bit period is exactly CLK_DIV clocks. A 16-bit counter wraps at CLK_DIV-1.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: a high-to-low transition on rxs starts the counter at 0 and enters START.
  - START: at count CLK_DIV/2-1 (integer division), rxs is sampled.
    - rxs=1: glitch. Return to IDLE with no output.
    - rxs=0: enter DATA.
  - DATA/PARITY/STOP: sample rxs every CLK_DIV clocks after the mid-start point. Data is shifted in LSB first.
  - At the mid-stop sample, in one cycle: update rx_data, pulse rx_valid, set frame_err = ~rxs, set parity_err = computed≠received. Return to IDLE immediately so a following start edge is caught within the stop bit.
  - The error flags hold until the next rx_valid.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - A send with busy=0 latches tx_data.
  - busy and the start bit (tx=0) appear on the cycle after send.
  - Data goes out LSB first, then the parity bit, then STOP_BITS high bits, each lasting CLK_DIV clocks.
  - busy falls on the cycle after the last stop bit completes. A send on that same cycle is accepted.
  - A send with busy=1 is ignored; no queueing.
- Parity bit = XOR of the data bits; inverted for odd.
- RX and TX are fully independent. Loopback (tx tied to rx) is legal.
- A reset during a frame aborts it. tx returns high on the next cycle and no rx_valid is generated.

## Timing
- TX frame length in clocks: (1+DATA_BITS+P+STOP_BITS)*CLK_DIV, where P=1 if parity is active, else 0.
- TX latency: send to tx falling = 1 clock.
- RX latency: rx line start edge to rx_valid = 2 (sync) + 1 (edge) + CLK_DIV/2-1 + (DATA_BITS+P+1)*CLK_DIV clocks.
- RX tolerates ±3% baud mismatch at CLK_DIV ≥ 16.
- No combinational path from any input to any output. All outputs are registered.

## Configuration
- UART_PARITY_EN defined: the PARITY parameter is honoured. The parity bit is generated on TX and checked on RX, with parity_err as specified.
- UART_PARITY_EN undefined: the parity logic and PARITY state are not compiled in. Frames are always no-parity regardless of PARITY, and parity_err is constant 0.

## Test plan
- CLK_DIV=16, 8N1, send 0xA5: tx = 0,1,0,1,0,0,1,0,1,1 with 16 clocks per bit; busy high for exactly 160 clocks.
- Loopback, 8N1, send 0x00, 0xFF, 0x3C back to back (each sent on the busy fall): three rx_valid pulses with matching rx_data and no errors.
- rx low pulse of CLK_DIV/4 clocks: no rx_valid; the next valid frame 0x55 is received correctly.
- Frame 0x81 with stop bit driven low: rx_valid with rx_data=0x81 and frame_err=1. The next good frame clears frame_err.
- UART_PARITY_EN, DATA_BITS=7, PARITY=1 (odd), send 0x35: parity bit = 1. Injecting a flipped parity bit on RX gives parity_err=1.
- reset asserted mid-TX at data bit 3: tx=1 and busy=0 the next cycle. A send while busy=1 is ignored, checked by frame count.
